// File: rtl/sample_uart_framer_pkg.sv
// sample_uart_framer_pkg: shared UART framing constants, FSM encoding and frame helper
package sample_uart_framer_pkg;
  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  typedef enum logic [1:0] {IDLE, WAIT_IDLE, REQ, WAIT_ACK} state_t;
  function automatic int last_index(input int sample_bits);
    return sample_bits / 8;
  endfunction
endpackage

// File: rtl/sample_uart_framer_sync_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read data
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr = '0;
  logic [AW-1:0]    r_rd_ptr = '0;
  logic [CW-1:0]    r_count = '0;
  logic             w_push;
  logic             w_pop;
  assign full   = r_count == CW'(DEPTH);
  assign empty  = r_count == '0;
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign dout   = r_mem[r_rd_ptr];
  assign count  = r_count;
  // storage write; contents need no reset since pointers gate visibility
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= din;
  // pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk)
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_count  <= r_count + CW'(w_push) - CW'(w_pop);
    end
endmodule

// File: rtl/sample_uart_framer.sv
// sample_uart_framer: buffers audio samples and emits sync-prefixed byte frames over a UART handshake
module sample_uart_framer
  import sample_uart_framer_pkg::*;
#(
  parameter int         SAMPLE_BITS = 16,
  parameter int         FIFO_DEPTH  = 8,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [SAMPLE_BITS-1:0]       sample_in,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic [7:0]                   tx_byte,
  output logic                         send,
  input  logic                         tx_ready,
  output logic                         overflow,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);
  localparam int NB = last_index(SAMPLE_BITS);
  localparam int IW = $clog2(NB + 1);
  state_t                 r_state = IDLE;
  state_t                 w_state_nx;
  logic [IW-1:0]          r_idx = '0;
  logic [SAMPLE_BITS-1:0] r_frame = '0;
  logic [7:0]             r_tx_byte = '0;
  logic                   r_send = 1'b0;
  logic                   r_overflow = 1'b0;
  logic [SAMPLE_BITS-1:0] w_fifo_dout;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_pop;
  logic                   w_load_sync;
  logic                   w_load_data;
  logic                   w_last;
  assign sample_ready = ~w_full;
  assign w_last       = r_idx == IW'(NB);
  assign tx_byte      = r_tx_byte;
  assign send         = r_send;
  assign overflow     = r_overflow;
  sync_fifo #(.WIDTH(SAMPLE_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (sample_valid & sample_ready),
    .din   (sample_in),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (fifo_count)
  );
  // next-state: a byte is only offered once the transmitter reports idle, and advances after it has taken and finished it
  always_comb begin
    w_state_nx  = r_state;
    w_pop       = 1'b0;
    w_load_sync = 1'b0;
    w_load_data = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop      = ~w_empty;
        w_state_nx = w_empty ? IDLE : WAIT_IDLE;
      end
      WAIT_IDLE: begin
        w_load_sync = tx_ready;
        w_state_nx  = tx_ready ? REQ : WAIT_IDLE;
      end
      REQ: w_state_nx = tx_ready ? REQ : WAIT_ACK;
      WAIT_ACK: begin
        w_load_data = tx_ready & ~w_last;
        w_state_nx  = ~tx_ready ? WAIT_ACK : (w_last ? IDLE : REQ);
      end
      default: w_state_nx = IDLE;
    endcase
  end
  // state, frame shift register, registered byte/send outputs and sticky overflow
  always_ff @(posedge clk)
    if (rst) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_frame    <= '0;
      r_tx_byte  <= 8'h00;
      r_send     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_send  <= w_state_nx == REQ;
      if (w_pop) begin
        r_frame <= w_fifo_dout;
        r_idx   <= '0;
      end
      if (w_load_sync) r_tx_byte <= SYNC_BYTE;
      if (w_load_data) begin
        r_tx_byte <= r_frame[SAMPLE_BITS-1 -: 8];
        r_frame   <= r_frame << 8;
        r_idx     <= r_idx + IW'(1);
      end
      if (sample_valid & ~sample_ready) r_overflow <= 1'b1;
    end
endmodule
